// File: rtl/result_router_n.sv
// result_router_n: registered 1-to-NUM_CH result router.
//
// Accepts one DATA_W-bit result per cycle under a valid/ready handshake. The
// result goes to the channel named by in_sel, or to every channel when
// in_bcast is set. Each channel has its own single-entry output register with
// independent valid/ready, so one stalled consumer never disturbs another.
//
// Optional build macro: ROUTER_SEL_CHK_EN adds the sel_err output, which
// pulses for one cycle after an accepted out-of-range (non-broadcast) select.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   in_data      result to route
//   in_sel       destination channel index
//   in_bcast     write the result to every channel
//   in_valid     input valid
//   in_ready     router accepts this cycle (independent of in_valid)
//   out_data     channel i at bits [i*DATA_W +: DATA_W]
//   out_valid    channel register i holds data
//   out_ready    consumer i takes data this cycle
//   sel_err      (ROUTER_SEL_CHK_EN only) out-of-range select was dropped
module result_router_n #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned SEL_W  = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic                     in_bcast,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready
`ifdef ROUTER_SEL_CHK_EN
  ,
  output logic                     sel_err
`endif
);

  logic [NUM_CH*DATA_W-1:0] data_q;
  logic [NUM_CH-1:0]        valid_q;
  logic [NUM_CH-1:0]        can_load;
  logic [NUM_CH-1:0]        target;
  logic [NUM_CH-1:0]        load;
  logic                     sel_ok;
  logic                     accept;

  always_comb begin
    can_load = ~valid_q | out_ready;
    sel_ok   = 32'(in_sel) < NUM_CH;
    target   = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      target[i] = in_bcast | (32'(in_sel) == i);
    end
    // Broadcast waits until every channel can take the result, so it is
    // never partially written. Out-of-range selects are always accepted and
    // dropped (target is all zero in that case).
    if (in_bcast) begin
      in_ready = &can_load;
    end else if (sel_ok) begin
      in_ready = |(target & can_load);
    end else begin
      in_ready = 1'b1;
    end
    accept = in_valid & in_ready;
    load   = accept ? target : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        // Load wins over drain, giving back-to-back transfers with no bubble.
        if (load[i]) begin
          valid_q[i]                <= 1'b1;
          data_q[i*DATA_W +: DATA_W] <= in_data;
        end else if (out_ready[i]) begin
          valid_q[i] <= 1'b0;
        end
      end
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;

`ifdef ROUTER_SEL_CHK_EN
  logic sel_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= accept & ~in_bcast & ~sel_ok;
    end
  end

  assign sel_err = sel_err_q;
`endif

endmodule

// File: tb/tb_result_router_n.sv
module tb_result_router_n;

  logic clk;
  logic rst_n;

  // dut2: NUM_CH=2, SEL_W=1
  logic [31:0] a_in_data;
  logic [0:0]  a_in_sel;
  logic        a_in_bcast, a_in_valid, a_in_ready;
  logic [63:0] a_out_data;
  logic [1:0]  a_out_valid, a_out_ready;

  // dut4: NUM_CH=4, SEL_W=2
  logic [31:0]  b_in_data;
  logic [1:0]   b_in_sel;
  logic         b_in_bcast, b_in_valid, b_in_ready;
  logic [127:0] b_out_data;
  logic [3:0]   b_out_valid, b_out_ready;

  // dut3: NUM_CH=3, SEL_W=2
  logic [31:0] c_in_data;
  logic [1:0]  c_in_sel;
  logic        c_in_bcast, c_in_valid, c_in_ready;
  logic [95:0] c_out_data;
  logic [2:0]  c_out_valid, c_out_ready;

`ifdef ROUTER_SEL_CHK_EN
  logic a_sel_err, b_sel_err, c_sel_err;
`endif

  int total;
  int bad;

  result_router_n #(.DATA_W(32), .NUM_CH(2), .SEL_W(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_data(a_in_data), .in_sel(a_in_sel),
    .in_bcast(a_in_bcast), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready)
`ifdef ROUTER_SEL_CHK_EN
    , .sel_err(a_sel_err)
`endif
  );

  result_router_n #(.DATA_W(32), .NUM_CH(4), .SEL_W(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_sel(b_in_sel),
    .in_bcast(b_in_bcast), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready)
`ifdef ROUTER_SEL_CHK_EN
    , .sel_err(b_sel_err)
`endif
  );

  result_router_n #(.DATA_W(32), .NUM_CH(3), .SEL_W(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(c_in_data), .in_sel(c_in_sel),
    .in_bcast(c_in_bcast), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .out_data(c_out_data), .out_valid(c_out_valid), .out_ready(c_out_ready)
`ifdef ROUTER_SEL_CHK_EN
    , .sel_err(c_sel_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    a_in_data = '0; a_in_sel = '0; a_in_bcast = 0; a_in_valid = 0; a_out_ready = '0;
    b_in_data = '0; b_in_sel = '0; b_in_bcast = 0; b_in_valid = 0; b_out_ready = '0;
    c_in_data = '0; c_in_sel = '0; c_in_bcast = 0; c_in_valid = 0; c_out_ready = '0;
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (a_out_valid !== 2'b00) begin
      bad++; $display("FAIL reset_valid2: got %b want 00", a_out_valid);
    end
    total++;
    if (a_out_data !== 64'h0) begin
      bad++; $display("FAIL reset_data2: got %h want 0", a_out_data);
    end
    total++;
    if (b_out_valid !== 4'b0000 || b_out_data !== 128'h0) begin
      bad++; $display("FAIL reset_dut4: got v=%b d=%h want 0", b_out_valid, b_out_data);
    end
    total++;
    if (c_out_valid !== 3'b000 || c_out_data !== 96'h0) begin
      bad++; $display("FAIL reset_dut3: got v=%b d=%h want 0", c_out_valid, c_out_data);
    end
`ifdef ROUTER_SEL_CHK_EN
    total++;
    if (c_sel_err !== 1'b0) begin
      bad++; $display("FAIL reset_sel_err: got %b want 0", c_sel_err);
    end
`endif
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    a_out_ready = 2'b11;
    a_in_data = 32'hDEAD_BEEF; a_in_sel = 1'b1; a_in_valid = 1'b1;
    #1;
    total++;
    if (a_in_ready !== 1'b1) begin
      bad++; $display("FAIL basic_in_ready: got %b want 1", a_in_ready);
    end
    step();
    a_in_valid = 1'b0;
    total++;
    if (a_out_valid !== 2'b10) begin
      bad++; $display("FAIL basic_valid: got %b want 10", a_out_valid);
    end
    total++;
    if (a_out_data[63:32] !== 32'hDEAD_BEEF || a_out_data[31:0] !== 32'h0) begin
      bad++; $display("FAIL basic_data: got %h want deadbeef_00000000", a_out_data);
    end
    step();
    total++;
    if (a_out_valid !== 2'b00 || a_out_data[63:32] !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL basic_drain: got v=%b d=%h want v=00 ch1=deadbeef",
                      a_out_valid, a_out_data);
    end
  endtask

  task automatic test_backpressure();
    a_out_ready = 2'b00;
    a_in_data = 32'hAAAA_0001; a_in_sel = 1'b0; a_in_valid = 1'b1;
    step();
    a_in_data = 32'hBBBB_0002;
    #1;
    total++;
    if (a_in_ready !== 1'b0) begin
      bad++; $display("FAIL bp_in_ready_full: got %b want 0", a_in_ready);
    end
    step();
    total++;
    if (a_out_valid !== 2'b01 || a_out_data[31:0] !== 32'hAAAA_0001) begin
      bad++; $display("FAIL bp_hold_a: got v=%b d=%h want v=01 ch0=aaaa0001",
                      a_out_valid, a_out_data[31:0]);
    end
    a_out_ready = 2'b01;
    #1;
    total++;
    if (a_in_ready !== 1'b1) begin
      bad++; $display("FAIL bp_in_ready_release: got %b want 1", a_in_ready);
    end
    step();
    a_in_valid = 1'b0;
    total++;
    if (a_out_valid !== 2'b01 || a_out_data[31:0] !== 32'hBBBB_0002) begin
      bad++; $display("FAIL bp_b_arrives: got v=%b d=%h want v=01 ch0=bbbb0002",
                      a_out_valid, a_out_data[31:0]);
    end
    step();
    total++;
    if (a_out_valid !== 2'b00) begin
      bad++; $display("FAIL bp_drain: got %b want 00", a_out_valid);
    end
  endtask

  task automatic test_drain_load();
    a_out_ready = 2'b00;
    a_in_data = 32'h1111_000A; a_in_sel = 1'b0; a_in_valid = 1'b1;
    step();
    a_out_ready = 2'b01;
    a_in_data = 32'h2222_000B;
    step();
    a_in_valid = 1'b0;
    total++;
    if (a_out_valid !== 2'b01 || a_out_data[31:0] !== 32'h2222_000B) begin
      bad++; $display("FAIL dl_no_bubble: got v=%b d=%h want v=01 ch0=2222000b",
                      a_out_valid, a_out_data[31:0]);
    end
    step();
    total++;
    if (a_out_valid !== 2'b00 || a_out_data[31:0] !== 32'h2222_000B) begin
      bad++; $display("FAIL dl_hold_last: got v=%b d=%h want v=00 ch0=2222000b",
                      a_out_valid, a_out_data[31:0]);
    end
  endtask

  task automatic test_bcast();
    b_out_ready = 4'b0000;
    b_in_data = 32'h0000_0055; b_in_sel = 2'd2; b_in_bcast = 1'b0; b_in_valid = 1'b1;
    step();
    b_in_data = 32'h0000_1234; b_in_bcast = 1'b1;
    #1;
    total++;
    if (b_in_ready !== 1'b0) begin
      bad++; $display("FAIL bc_stall_ready: got %b want 0", b_in_ready);
    end
    step();
    total++;
    if (b_out_valid !== 4'b0100 || b_out_data[95:64] !== 32'h55 || b_out_data[31:0] !== 32'h0)
    begin
      bad++; $display("FAIL bc_no_partial: got v=%b d=%h want v=0100 ch2=55 ch0=0",
                      b_out_valid, b_out_data);
    end
    b_out_ready = 4'b0100;
    #1;
    total++;
    if (b_in_ready !== 1'b1) begin
      bad++; $display("FAIL bc_release_ready: got %b want 1", b_in_ready);
    end
    step();
    b_in_valid = 1'b0; b_in_bcast = 1'b0;
    total++;
    if (b_out_valid !== 4'b1111) begin
      bad++; $display("FAIL bc_valid_all: got %b want 1111", b_out_valid);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (b_out_data[i*32 +: 32] !== 32'h0000_1234) begin
        bad++; $display("FAIL bc_data_ch%0d: got %h want 00001234", i, b_out_data[i*32 +: 32]);
      end
    end
    b_out_ready = 4'b1111;
    step();
  endtask

  task automatic test_out_of_range();
    c_out_ready = 3'b000;
    c_in_data = 32'hCAFE_0003; c_in_sel = 2'd2; c_in_bcast = 1'b0; c_in_valid = 1'b1;
    step();
    total++;
    if (c_out_valid !== 3'b100 || c_out_data[95:64] !== 32'hCAFE_0003) begin
      bad++; $display("FAIL oor_top_channel: got v=%b d=%h want v=100 ch2=cafe0003",
                      c_out_valid, c_out_data[95:64]);
    end
    c_in_data = 32'hBAD0_0BAD; c_in_sel = 2'd3;
    #1;
    total++;
    if (c_in_ready !== 1'b1) begin
      bad++; $display("FAIL oor_in_ready: got %b want 1", c_in_ready);
    end
    step();
    c_in_valid = 1'b0;
    total++;
    if (c_out_valid !== 3'b100 || c_out_data !== {32'hCAFE_0003, 64'h0}) begin
      bad++; $display("FAIL oor_dropped: got v=%b d=%h want v=100 d=cafe0003_0_0",
                      c_out_valid, c_out_data);
    end
`ifdef ROUTER_SEL_CHK_EN
    total++;
    if (c_sel_err !== 1'b1) begin
      bad++; $display("FAIL oor_sel_err_pulse: got %b want 1", c_sel_err);
    end
`endif
    step();
`ifdef ROUTER_SEL_CHK_EN
    total++;
    if (c_sel_err !== 1'b0) begin
      bad++; $display("FAIL oor_sel_err_clear: got %b want 0", c_sel_err);
    end
`endif
    c_out_ready = 3'b111;
    step();
  endtask

  task automatic test_reset_mid();
    a_out_ready = 2'b00;
    a_in_data = 32'h0C0C_0000; a_in_sel = 1'b0; a_in_valid = 1'b1;
    step();
    a_in_data = 32'h0C0C_0001; a_in_sel = 1'b1;
    step();
    a_in_valid = 1'b0;
    total++;
    if (a_out_valid !== 2'b11) begin
      bad++; $display("FAIL rm_pre_valid: got %b want 11", a_out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (a_out_valid !== 2'b00 || a_out_data !== 64'h0) begin
      bad++; $display("FAIL rm_async_clear: got v=%b d=%h want 0", a_out_valid, a_out_data);
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_drain_load();
    test_bcast();
    test_out_of_range();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
